// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads own the BRAM during the active region,
// the image-processing engine is served in blanking through a req/ack handshake.
module vga_fb_arbiter #(
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              disp_active,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    input  logic              proc_req,
    input  logic              proc_we,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [DATA_W-1:0] proc_wdata,
    output logic              proc_ack,
    output logic [DATA_W-1:0] proc_rdata,
    output logic              proc_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              stall_clr,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {OwnIdle, OwnDisp, OwnProc} owner_e;

    owner_e owner;
    logic   rd_issue;
    logic   ret_vld;
    logic   ret_proc;

    // Stage i of the tag pipe describes the access issued i edges ago.
    logic [MEM_LAT:0] tag_vld;
    logic [MEM_LAT:0] tag_proc;

    // A request still high while proc_ack is high is the already-served one.
    always_comb begin
        owner = OwnIdle;
        if (disp_active) begin
            owner = OwnDisp;
        end else if (proc_req && !proc_ack) begin
            owner = OwnProc;
        end
    end

    assign rd_issue = (owner == OwnDisp) || ((owner == OwnProc) && !proc_we);
    assign ret_vld  = tag_vld[MEM_LAT];
    assign ret_proc = tag_proc[MEM_LAT];

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            proc_ack  <= 1'b0;
        end else begin
            proc_ack <= (owner == OwnProc);
            unique case (owner)
                OwnDisp: begin
                    mem_en   <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= disp_addr;
                end
                OwnProc: begin
                    mem_en    <= 1'b1;
                    mem_we    <= proc_we;
                    mem_addr  <= proc_addr;
                    mem_wdata <= proc_wdata;
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            tag_vld  <= '0;
            tag_proc <= '0;
        end else begin
            tag_vld  <= {tag_vld[MEM_LAT-1:0], rd_issue};
            tag_proc <= {tag_proc[MEM_LAT-1:0], owner == OwnProc};
        end
    end

    // Cycles with no display read in the return slot show black.
    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            disp_data   <= '0;
            proc_rdata  <= '0;
            proc_rvalid <= 1'b0;
        end else begin
            disp_data   <= (ret_vld && !ret_proc) ? mem_rdata : '0;
            proc_rvalid <= ret_vld && ret_proc;
            if (ret_vld && ret_proc) begin
                proc_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (proc_req && (owner != OwnProc) && !proc_ack && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter: a cycle-indexed scoreboard of grants, memory contents
// and scheduled returns predicts every output; a small BRAM model closes the memory loop.
module tb_vga_fb_arbiter;

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 12;

    logic          vga_clk;
    logic          rst;
    logic          disp_active;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          proc_req;
    logic          proc_we;
    logic [AW-1:0] proc_addr;
    logic [DW-1:0] proc_wdata;
    logic          proc_ack;
    logic [DW-1:0] proc_rdata;
    logic          proc_rvalid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_clr;
    logic [15:0]   stall_cnt;

    vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .disp_active (disp_active),
        .disp_addr   (disp_addr),
        .disp_data   (disp_data),
        .proc_req    (proc_req),
        .proc_we     (proc_we),
        .proc_addr   (proc_addr),
        .proc_wdata  (proc_wdata),
        .proc_ack    (proc_ack),
        .proc_rdata  (proc_rdata),
        .proc_rvalid (proc_rvalid),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .stall_clr   (stall_clr),
        .stall_cnt   (stall_cnt)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // BRAM with one cycle read latency; the bench only uses addresses below 1024.
    logic [DW-1:0] bram [0:1023];
    always @(posedge vga_clk) begin
        if (mem_en) begin
            if (mem_we) bram[mem_addr[9:0]] <= mem_wdata;
            else        mem_rdata <= bram[mem_addr[9:0]];
        end
    end

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Reference state: memory image, expected outputs for the current cycle, return slots.
    logic [DW-1:0] ref_mem [0:1023];
    logic          cur_ack, cur_en, cur_we, cur_rv;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata, cur_dd, cur_rd;
    logic [15:0]   cur_stall;
    logic          ret_dv [0:7];
    logic [DW-1:0] ret_dd [0:7];
    logic          ret_rv [0:7];
    logic [DW-1:0] ret_rd [0:7];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_outputs();
        check_eq("proc_ack", {31'd0, proc_ack}, {31'd0, cur_ack});
        check_eq("mem_en", {31'd0, mem_en}, {31'd0, cur_en});
        check_eq("mem_we", {31'd0, mem_we}, {31'd0, cur_we});
        check_eq("mem_addr", {13'd0, mem_addr}, {13'd0, cur_addr});
        check_eq("mem_wdata", {20'd0, mem_wdata}, {20'd0, cur_wdata});
        check_eq("disp_data", {20'd0, disp_data}, {20'd0, cur_dd});
        check_eq("proc_rvalid", {31'd0, proc_rvalid}, {31'd0, cur_rv});
        check_eq("proc_rdata", {20'd0, proc_rdata}, {20'd0, cur_rd});
        check_eq("stall_cnt", {16'd0, stall_cnt}, {16'd0, cur_stall});
    endtask

    task automatic clear_model();
        cur_ack = 0; cur_en = 0; cur_we = 0; cur_rv = 0;
        cur_addr = '0; cur_wdata = '0; cur_dd = '0; cur_rd = '0; cur_stall = '0;
        for (int i = 0; i < 8; i++) begin
            ret_dv[i] = 0; ret_dd[i] = '0; ret_rv[i] = 0; ret_rd[i] = '0;
        end
    endtask

    // Apply the inputs currently driven for one clock, then check the next cycle's outputs.
    task automatic cycle();
        logic          g_disp, g_proc, n_ack, n_en, n_we;
        logic [AW-1:0] n_addr;
        logic [DW-1:0] n_wdata;
        logic [15:0]   n_stall;
        int            slot;
        g_disp  = disp_active;
        g_proc  = !disp_active && proc_req && !cur_ack;
        n_ack   = g_proc;
        n_en    = g_disp || g_proc;
        n_we    = g_proc && proc_we;
        n_addr  = g_disp ? disp_addr : (g_proc ? proc_addr : cur_addr);
        n_wdata = g_proc ? proc_wdata : cur_wdata;
        slot    = (cyc + 3) % 8;
        if (g_disp) begin
            ret_dv[slot] = 1;
            ret_dd[slot] = ref_mem[disp_addr[9:0]];
        end
        if (g_proc && !proc_we) begin
            ret_rv[slot] = 1;
            ret_rd[slot] = ref_mem[proc_addr[9:0]];
        end
        if (g_proc && proc_we) ref_mem[proc_addr[9:0]] = proc_wdata;
        if (stall_clr) n_stall = 0;
        else if (proc_req && !g_proc && !cur_ack)
            n_stall = (cur_stall == 16'hFFFF) ? cur_stall : cur_stall + 16'd1;
        else n_stall = cur_stall;

        @(posedge vga_clk);
        @(negedge vga_clk);
        cyc++;
        slot      = cyc % 8;
        cur_ack   = n_ack;
        cur_en    = n_en;
        cur_we    = n_we;
        cur_addr  = n_addr;
        cur_wdata = n_wdata;
        cur_stall = n_stall;
        cur_dd    = ret_dv[slot] ? ret_dd[slot] : '0;
        cur_rv    = ret_rv[slot];
        if (ret_rv[slot]) cur_rd = ret_rd[slot];
        ret_dv[slot] = 0;
        ret_rv[slot] = 0;
        check_outputs();
    endtask

    task automatic set_idle();
        disp_active = 0;
        proc_req    = 0;
        stall_clr   = 0;
    endtask

    // Called at a falling edge; asserts reset mid-cycle, checks zeros, releases a cycle later.
    task automatic do_reset();
        set_idle();
        #1 rst = 0;
        #1;
        clear_model();
        check_outputs();
        @(posedge vga_clk);
        @(negedge vga_clk);
        rst = 1;
    endtask

    initial begin
        rst         = 0;
        disp_active = 0;
        disp_addr   = '0;
        proc_req    = 0;
        proc_we     = 0;
        proc_addr   = '0;
        proc_wdata  = '0;
        stall_clr   = 0;
        for (int i = 0; i < 1024; i++) begin
            bram[i]    = DW'(i * 3);
            ref_mem[i] = DW'(i * 3);
        end
        clear_model();
        @(negedge vga_clk);
        do_reset();

        // Display reads of addresses 0..3.
        for (int i = 0; i < 4; i++) begin
            disp_active = 1;
            disp_addr   = AW'(i);
            cycle();
        end
        set_idle();
        repeat (4) cycle();

        // Processor write of 12'hABC to 100, then a display read of 100.
        proc_req = 1; proc_we = 1; proc_addr = 100; proc_wdata = 12'hABC;
        cycle();
        proc_req = 0;
        cycle();
        disp_active = 1; disp_addr = 100;
        cycle();
        set_idle();
        repeat (4) cycle();
        check_eq("disp_abc_seen", {20'd0, bram[100]}, 32'hABC);

        // Held read request at 100: acks on alternate cycles only.
        proc_req = 1; proc_we = 0; proc_addr = 100;
        repeat (8) cycle();
        set_idle();
        repeat (4) cycle();

        // 40 active cycles of stalling, then blanking, then a clear under a live request.
        stall_clr = 1;
        cycle();
        stall_clr = 0;
        proc_req = 1; proc_we = 0; proc_addr = 7; disp_active = 1;
        for (int i = 0; i < 40; i++) begin
            disp_addr = AW'(i);
            cycle();
        end
        check_eq("stall40", {16'd0, stall_cnt}, 32'd40);
        disp_active = 0;
        cycle();
        check_eq("ack_first_blank", {31'd0, proc_ack}, 32'd1);
        disp_active = 1;
        cycle();
        stall_clr = 1;
        cycle();
        check_eq("stall_clr", {16'd0, stall_cnt}, 32'd0);
        stall_clr = 0;
        repeat (3) cycle();
        set_idle();
        repeat (4) cycle();

        // Randomized traffic with legal processor handshakes.
        for (int i = 0; i < 3000; i++) begin
            disp_active = ($urandom_range(0, 99) < 40);
            disp_addr   = AW'($urandom_range(0, 63));
            stall_clr   = ($urandom_range(0, 49) == 0);
            if (!proc_req || cur_ack) begin
                proc_we    = $urandom_range(0, 1) == 1;
                proc_addr  = AW'($urandom_range(0, 63));
                proc_wdata = DW'($urandom);
                proc_req   = ($urandom_range(0, 3) != 0);
            end else begin
                proc_req = ($urandom_range(0, 15) != 0);
            end
            cycle();
        end
        set_idle();
        repeat (4) cycle();

        // Reset while a display read and then a processor read are in flight.
        disp_active = 1; disp_addr = 9;
        cycle();
        do_reset();
        repeat (4) cycle();
        proc_req = 1; proc_we = 0; proc_addr = 12;
        cycle();
        do_reset();
        repeat (4) cycle();

        // Stall counter saturation.
        disp_active = 1; proc_req = 1; proc_we = 0; proc_addr = 3; disp_addr = 5;
        repeat (70000) cycle();
        check_eq("stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
        set_idle();
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Single-port frame-buffer arbiter between the VGA display read path and the image-processing engine (read/write).
- Display reads have absolute priority while the pixel is in the active region.
- The processor is served only in blanking cycles, through a req/ack handshake.
- Sits between the display timing block (pixel address/active flag) and the 640x480 12-bit frame-buffer BRAM.

Parameters:
- ADDR_W, 19, frame-buffer address width.
- DATA_W, 12, pixel width (RGB444).
- MEM_LAT, 1, BRAM read latency in cycles from registered mem_en to mem_rdata valid; legal range 1..4.

Ports:
- vga_clk  in  1  pixel clock, single clock domain.
- rst  in  1  asynchronous, active-low reset.
- disp_active  in  1  display is in the active region this cycle.
- disp_addr  in  ADDR_W  display pixel address.
- disp_data  out  DATA_W  returned display pixel.
- proc_req  in  1  processor access request; held with stable fields until proc_ack.
- proc_we  in  1  1 = write, 0 = read.
- proc_addr  in  ADDR_W  processor address.
- proc_wdata  in  DATA_W  processor write data.
- proc_ack  out  1  one-cycle pulse: request accepted and issued to memory.
- proc_rdata  out  DATA_W  processor read data; holds its value between reads.
- proc_rvalid  out  1  one-cycle pulse: proc_rdata updated.
- mem_en, mem_we  out  1  BRAM enable and write enable (registered).
- mem_addr  out  ADDR_W  BRAM address (registered).
- mem_wdata  out  DATA_W  BRAM write data (registered).
- mem_rdata  in  DATA_W  BRAM read data.
- stall_clr  in  1  synchronous clear for stall_cnt.
- stall_cnt  out  16  saturating count of processor wait cycles.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0.
  - Owner tag pipeline is cleared; in-flight reads are discarded.
  - No proc_ack or proc_rvalid is produced for a request pending at reset.
- Decision cycle t, three-state owner select:
  - DISP if disp_active=1.
  - PROC if disp_active=0, proc_req=1 and proc_ack is not asserted in cycle t.
  - IDLE otherwise.
- At edge t+1:
  - mem_* are registered from the winner: DISP gives en=1, we=0, addr=disp_addr; PROC gives en=1, we=proc_we, addr=proc_addr, wdata=proc_wdata; IDLE gives en=0, we=0, addr and wdata hold their previous values.
  - proc_ack=1 for exactly one cycle when the winner was PROC.
- Ack blocking: a proc_req still high in the cycle proc_ack is high is a stale request and is not granted. Maximum processor rate is therefore one access per 2 cycles.
- Tag pipeline: a shift register of depth MEM_LAT+1 holding {valid, owner}, entered at t+1 with the mem_* issue. Writes enter as invalid.
- Read return for an access issued at edge t+1, registered at edge t+2+MEM_LAT:
  - DISP tag: disp_data <= mem_rdata.
  - PROC read tag: proc_rdata <= mem_rdata, proc_rvalid pulses 1 cycle.
  - No valid DISP tag at that stage: disp_data <= 0 (blank black).
- Display latency disp_addr -> disp_data is MEM_LAT+2 cycles (3 at default). The timing block compensates.
- A processor write lands in BRAM one edge after proc_ack. A same-address display read issued at a later cycle returns the new data.
- disp_active rising while a proc_req is pending: the display wins immediately and the processor waits for the next blanking cycle. There is no preemption of an already-acked access.
- stall_cnt:
  - +1 each cycle with proc_req=1, winner not PROC, and proc_ack=0.
  - Saturates at 16'hFFFF.
  - stall_clr takes priority over increment and sets the counter to 0 on the next edge.
- proc_req dropping before ack: the request is withdrawn and no access is made. This is legal only in cycles where the request has not been granted.

Test Plan:
- Reset, then disp_active=1 at disp_addr 0..3 with BRAM preloaded addr*3 -> disp_data 0,3,6,9 starting 3 cycles later; mem_we never 1.
- disp_active=0, proc write addr 100 data 12'hABC -> proc_ack at cycle +1; mem_en=1, mem_we=1, mem_addr=100; a display read of 100 later returns 12'hABC.
- disp_active=0, proc_req held high with a read at addr 100 -> single ack; proc_rvalid pulses 1 cycle, 3 cycles after the decision, with proc_rdata=12'hABC; back-to-back requests are acked on alternate cycles only.
- proc_req high through 40 active cycles, then blanking -> stall_cnt=40, ack on the first blank cycle; assert stall_clr -> stall_cnt=0 next cycle while the request continues.
- Hold proc_req with disp_active=1 for 70000 cycles -> stall_cnt saturates at 16'hFFFF.
- Issue a display read, assert rst low for 1 cycle before data return -> all outputs 0 and no disp_data or proc_rvalid update from the discarded read after release.
